risc_toy_dmem: RTL and testbench

- Data-memory responder on the far end of the RISC_TOY core's data port.
- Accepts DREQ/DRW/DADDR/DWDATA from the core, stores words in an internal array, and returns read data on DRDATA after a fixed, parameterised latency.
- Provides a read-valid strobe, an out-of-range error strobe, and saturating access counters for bring-up and verification.
- Sits beside RISC_TOY in the top-level testbench/SoC wrapper.

---
 rtl/risc_toy_dmem_pkg.sv | 20 ++
 rtl/risc_toy_dmem_if.sv | 24 ++
 rtl/risc_toy_dmem_array.sv | 30 +++
 rtl/risc_toy_dmem.sv | 101 ++++++++++
 tb/tb_risc_toy_dmem.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/risc_toy_dmem_pkg.sv
// risc_toy_pkg: shared definitions for the RISC_TOY data-memory responder.
//   DRW encoding, bus widths and the response record that flows through
//   the read-latency pipeline.
package risc_toy_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 30;

    localparam logic DRW_WRITE = 1'b1;
    localparam logic DRW_READ  = 1'b0;

    // One pipeline slot: valid marks a read response, err an out-of-range
    // request of either kind, data the word being returned.
    typedef struct packed {
        logic              valid;
        logic              err;
        logic [DATA_W-1:0] data;
    } resp_t;

endpackage

// File: rtl/risc_toy_dmem_if.sv
// risc_toy_dmem_if: core data-port bundle.
//   DREQ/DRW/DADDR/DWDATA : request from the core (master drives)
//   DRDATA/DVALID/ERR     : response from the memory (slave drives)
interface risc_toy_dmem_if;

    logic                             DREQ;
    logic                             DRW;
    logic [risc_toy_pkg::ADDR_W-1:0]  DADDR;
    logic [risc_toy_pkg::DATA_W-1:0]  DWDATA;
    logic [risc_toy_pkg::DATA_W-1:0]  DRDATA;
    logic                             DVALID;
    logic                             ERR;

    modport master (
        output DREQ, DRW, DADDR, DWDATA,
        input  DRDATA, DVALID, ERR
    );

    modport slave (
        input  DREQ, DRW, DADDR, DWDATA,
        output DRDATA, DVALID, ERR
    );

endinterface

// File: rtl/risc_toy_dmem_array.sv
// risc_toy_dmem_array: DEPTH x 32-bit word storage, no reset.
//   CLK     : clock
//   we_i    : write enable, write lands on the rising edge
//   addr_i  : word index shared by read and write (one request per cycle)
//   wdata_i : write data
//   rdata_o : contents at addr_i; the top captures it at the sample edge
module risc_toy_dmem_array
    import risc_toy_pkg::*;
#(
    parameter int DEPTH = 1024,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic              CLK,
    input  logic              we_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge CLK) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/risc_toy_dmem.sv
// risc_toy_dmem: data-memory responder for the RISC_TOY core.
//   CLK    : clock, all state on the rising edge
//   RSTN   : asynchronous active-low reset (array contents survive it)
//   bus    : slave side of the core data port (request in, response out)
//   RD_CNT : saturating count of accepted in-range reads
//   WR_CNT : saturating count of accepted in-range writes
// Read data and flags appear READ_LAT edges after the request edge.
module risc_toy_dmem
    import risc_toy_pkg::*;
#(
    parameter int DEPTH    = 1024,
    parameter int READ_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic             CLK,
    input  logic             RSTN,
    risc_toy_dmem_if.slave   bus,
    output logic [CNT_W-1:0] RD_CNT,
    output logic [CNT_W-1:0] WR_CNT
);

    localparam int              AW      = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic              in_range;
    logic              rd_req;
    logic              wr_req;
    logic [DATA_W-1:0] arr_rdata;

    resp_t             stage_q [READ_LAT];
    resp_t             stage_d [READ_LAT];
    logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;

    // Any nonzero bit above the index field is out of range; no aliasing.
    assign in_range = (bus.DADDR[ADDR_W-1:AW] == '0);
    assign rd_req   = bus.DREQ && (bus.DRW == DRW_READ);
    assign wr_req   = bus.DREQ && (bus.DRW == DRW_WRITE);

    risc_toy_dmem_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .CLK     (CLK),
        .we_i    (wr_req && in_range),
        .addr_i  (bus.DADDR[AW-1:0]),
        .wdata_i (bus.DWDATA),
        .rdata_o (arr_rdata)
    );

    // Data in each slot only moves when a read response moves, so the
    // last slot (and thus DRDATA) holds its value across idle cycles.
    always_comb begin
        stage_d = stage_q;

        stage_d[0].valid = rd_req;
        stage_d[0].err   = bus.DREQ && !in_range;
        if (rd_req) begin
            stage_d[0].data = in_range ? arr_rdata : '0;
        end

        for (int i = 1; i < READ_LAT; i++) begin
            stage_d[i].valid = stage_q[i-1].valid;
            stage_d[i].err   = stage_q[i-1].err;
            if (stage_q[i-1].valid) begin
                stage_d[i].data = stage_q[i-1].data;
            end
        end
    end

    always_comb begin
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        if (rd_req && in_range && (rd_cnt_q != '1)) begin
            rd_cnt_d = rd_cnt_q + CNT_ONE;
        end
        if (wr_req && in_range && (wr_cnt_q != '1)) begin
            wr_cnt_d = wr_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            for (int i = 0; i < READ_LAT; i++) begin
                stage_q[i] <= '0;
            end
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            stage_q  <= stage_d;
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    assign bus.DRDATA = stage_q[READ_LAT-1].data;
    assign bus.DVALID = stage_q[READ_LAT-1].valid;
    assign bus.ERR    = stage_q[READ_LAT-1].err;
    assign RD_CNT     = rd_cnt_q;
    assign WR_CNT     = wr_cnt_q;

endmodule

// File: tb/tb_risc_toy_dmem.sv
// tb_risc_toy_dmem: four responders (READ_LAT 1..4, the last with 4-bit
// counters) share one request stream; each scenario is checked on the
// instance whose latency it targets, against hand-computed values.
module tb_risc_toy_dmem;

    logic        CLK;
    logic        RSTN;
    logic        req;
    logic        rw;
    logic [29:0] addr;
    logic [31:0] wdata;

    logic [15:0] rd1, wr1, rd2, wr2, rd3, wr3;
    logic [3:0]  rd4, wr4;

    int n_chk;
    int n_fail;

    risc_toy_dmem_if if1 ();
    risc_toy_dmem_if if2 ();
    risc_toy_dmem_if if3 ();
    risc_toy_dmem_if if4 ();

    assign if1.DREQ = req;  assign if1.DRW = rw;  assign if1.DADDR = addr;  assign if1.DWDATA = wdata;
    assign if2.DREQ = req;  assign if2.DRW = rw;  assign if2.DADDR = addr;  assign if2.DWDATA = wdata;
    assign if3.DREQ = req;  assign if3.DRW = rw;  assign if3.DADDR = addr;  assign if3.DWDATA = wdata;
    assign if4.DREQ = req;  assign if4.DRW = rw;  assign if4.DADDR = addr;  assign if4.DWDATA = wdata;

    risc_toy_dmem #(.DEPTH(1024), .READ_LAT(1), .CNT_W(16)) d1 (
        .CLK(CLK), .RSTN(RSTN), .bus(if1), .RD_CNT(rd1), .WR_CNT(wr1));
    risc_toy_dmem #(.DEPTH(1024), .READ_LAT(2), .CNT_W(16)) d2 (
        .CLK(CLK), .RSTN(RSTN), .bus(if2), .RD_CNT(rd2), .WR_CNT(wr2));
    risc_toy_dmem #(.DEPTH(1024), .READ_LAT(3), .CNT_W(16)) d3 (
        .CLK(CLK), .RSTN(RSTN), .bus(if3), .RD_CNT(rd3), .WR_CNT(wr3));
    risc_toy_dmem #(.DEPTH(1024), .READ_LAT(4), .CNT_W(4)) d4 (
        .CLK(CLK), .RSTN(RSTN), .bus(if4), .RD_CNT(rd4), .WR_CNT(wr4));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic r, input logic w, input logic [29:0] a, input logic [31:0] d);
        req   = r;
        rw    = w;
        addr  = a;
        wdata = d;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        RSTN   = 1'b0;
        drive(1'b0, 1'b0, 30'd0, 32'd0);
        tick();
        tick();

        chk("rst_d1_drdata", if1.DRDATA, 32'h0);
        chk("rst_d1_dvalid", 32'(if1.DVALID), 32'h0);
        chk("rst_d1_err",    32'(if1.ERR), 32'h0);
        chk("rst_d1_rdcnt",  32'(rd1), 32'h0);
        chk("rst_d1_wrcnt",  32'(wr1), 32'h0);
        chk("rst_d4_dvalid", 32'(if4.DVALID), 32'h0);
        RSTN = 1'b1;

        // Basic write then read, latency 1
        drive(1'b1, 1'b1, 30'd5, 32'hDEADBEEF);
        tick();
        chk("basic_wr_dvalid", 32'(if1.DVALID), 32'h0);
        chk("basic_wr_cnt",    32'(wr1), 32'd1);
        drive(1'b1, 1'b0, 30'd5, 32'h0);
        tick();
        chk("basic_rd_dvalid", 32'(if1.DVALID), 32'h1);
        chk("basic_rd_data",   if1.DRDATA, 32'hDEADBEEF);
        chk("basic_rd_cnt",    32'(rd1), 32'd1);
        chk("basic_wr_cnt2",   32'(wr1), 32'd1);
        drive(1'b0, 1'b0, 30'd0, 32'h0);
        tick();
        chk("basic_idle_dvalid", 32'(if1.DVALID), 32'h0);
        chk("basic_hold_data",   if1.DRDATA, 32'hDEADBEEF);
        chk("basic_lat2_dvalid", 32'(if2.DVALID), 32'h1);
        chk("basic_lat2_data",   if2.DRDATA, 32'hDEADBEEF);

        // Streaming, latency 3
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1, 30'(i), 32'h100 + 32'(i));
            tick();
        end
        for (int k = 0; k < 12; k++) begin
            if (k < 8) drive(1'b1, 1'b0, 30'(k), 32'h0);
            else       drive(1'b0, 1'b0, 30'd0, 32'h0);
            tick();
            if (k >= 2 && k < 10) begin
                chk($sformatf("stream_l3_dvalid[%0d]", k), 32'(if3.DVALID), 32'h1);
                chk($sformatf("stream_l3_data[%0d]", k), if3.DRDATA, 32'h100 + 32'(k - 2));
            end else begin
                chk($sformatf("stream_l3_dvalid[%0d]", k), 32'(if3.DVALID), 32'h0);
            end
            if (k < 8) chk($sformatf("stream_l1_data[%0d]", k), if1.DRDATA, 32'h100 + 32'(k));
        end

        // Read-then-write hazard, latency 2
        drive(1'b1, 1'b1, 30'd9, 32'h11);
        tick();
        drive(1'b1, 1'b0, 30'd9, 32'h0);
        tick();
        drive(1'b1, 1'b1, 30'd9, 32'h22);
        tick();
        chk("hazard_l2_dvalid", 32'(if2.DVALID), 32'h1);
        chk("hazard_l2_old",    if2.DRDATA, 32'h11);
        drive(1'b1, 1'b0, 30'd9, 32'h0);
        tick();
        chk("hazard_l1_new", if1.DRDATA, 32'h22);
        drive(1'b0, 1'b0, 30'd0, 32'h0);
        tick();
        chk("hazard_l2_dvalid2", 32'(if2.DVALID), 32'h1);
        chk("hazard_l2_new",     if2.DRDATA, 32'h22);
        chk("tally_rd_cnt", 32'(rd1), 32'd11);
        chk("tally_wr_cnt", 32'(wr1), 32'd11);

        // Out of range accesses
        drive(1'b1, 1'b0, 30'h400, 32'h0);
        tick();
        chk("oor_rd_dvalid", 32'(if1.DVALID), 32'h1);
        chk("oor_rd_err",    32'(if1.ERR), 32'h1);
        chk("oor_rd_data",   if1.DRDATA, 32'h0);
        drive(1'b1, 1'b1, 30'h3FFFFFFF, 32'hBAD0BAD0);
        tick();
        chk("oor_wr_err",       32'(if1.ERR), 32'h1);
        chk("oor_wr_dvalid",    32'(if1.DVALID), 32'h0);
        chk("oor_rd_l2_dvalid", 32'(if2.DVALID), 32'h1);
        chk("oor_rd_l2_err",    32'(if2.ERR), 32'h1);
        chk("oor_rd_l2_data",   if2.DRDATA, 32'h0);
        chk("oor_rd_cnt",       32'(rd1), 32'd11);
        chk("oor_wr_cnt",       32'(wr1), 32'd11);
        drive(1'b1, 1'b0, 30'd0, 32'h0);
        tick();
        chk("oor_addr0_dvalid", 32'(if1.DVALID), 32'h1);
        chk("oor_addr0_err",    32'(if1.ERR), 32'h0);
        chk("oor_addr0_data",   if1.DRDATA, 32'h100);
        chk("oor_wr_l2_err",    32'(if2.ERR), 32'h1);
        chk("oor_wr_l2_dvalid", 32'(if2.DVALID), 32'h0);
        chk("oor_rd_cnt2",      32'(rd1), 32'd12);
        drive(1'b0, 1'b0, 30'd0, 32'h0);
        tick();

        // Reset mid-flight, latency 4
        drive(1'b1, 1'b0, 30'd1, 32'h0);
        tick();
        drive(1'b1, 1'b0, 30'd2, 32'h0);
        tick();
        RSTN = 1'b0;
        drive(1'b1, 1'b0, 30'd3, 32'h0);
        #1;
        chk("mrst_d4_dvalid", 32'(if4.DVALID), 32'h0);
        chk("mrst_d4_err",    32'(if4.ERR), 32'h0);
        chk("mrst_d4_rdcnt",  32'(rd4), 32'h0);
        chk("mrst_d1_rdcnt",  32'(rd1), 32'h0);
        chk("mrst_d1_wrcnt",  32'(wr1), 32'h0);
        chk("mrst_d1_drdata", if1.DRDATA, 32'h0);
        @(posedge CLK);
        #1;
        RSTN = 1'b1;
        drive(1'b0, 1'b0, 30'd0, 32'h0);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk($sformatf("mrst_flush_dvalid[%0d]", k), 32'(if4.DVALID), 32'h0);
            chk($sformatf("mrst_flush_err[%0d]", k), 32'(if4.ERR), 32'h0);
        end
        for (int k = 0; k < 5; k++) begin
            if (k == 0) drive(1'b1, 1'b0, 30'd1, 32'h0);
            else        drive(1'b0, 1'b0, 30'd0, 32'h0);
            tick();
            chk($sformatf("mrst_l4_dvalid[%0d]", k), 32'(if4.DVALID), (k == 3) ? 32'h1 : 32'h0);
            if (k == 3) chk("mrst_l4_data", if4.DRDATA, 32'h101);
            if (k == 0) chk("mrst_l1_data", if1.DRDATA, 32'h101);
        end
        chk("mrst_l4_rdcnt", 32'(rd4), 32'd1);

        // Counter saturation with 4-bit counters
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'b0, 30'd2, 32'h0);
            tick();
            if (i == 13) chk("sat_rd_cnt_reach", 32'(rd4), 32'd15);
        end
        drive(1'b0, 1'b0, 30'd0, 32'h0);
        chk("sat_rd_cnt_hold", 32'(rd4), 32'd15);
        chk("sat_wr_cnt",      32'(wr4), 32'd0);
        chk("sat_wide_rd_cnt", 32'(rd1), 32'd21);
        chk("sat_l4_data",     if4.DRDATA, 32'h102);
        tick();
        tick();
        tick();
        tick();
        chk("drain_l4_dvalid", 32'(if4.DVALID), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
